// File: rtl/median_band_feeder_if.sv
// Pixel-stream input and row-parallel column output of the median band feeder.
// Parameters must match the feeder instance the interface is bound to.
interface median_band_feeder_if #(
  parameter int SIZE   = 10,
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 66
);
  localparam int NBANDS = (HEIGHT - 2) / (SIZE - 2);
  localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW     = (NBANDS > 1) ? $clog2(NBANDS) : 1;

  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          frame_start;
  logic          pix_ready;
  logic [7:0]    arr_out [SIZE-1:0];
  logic          col_valid;
  logic [CW-1:0] col_idx;
  logic [BW-1:0] band_idx;
  logic          frame_done;

  modport master (
    output pix_in, pix_valid, frame_start,
    input  pix_ready, arr_out, col_valid, col_idx, band_idx, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, frame_start,
    output pix_ready, arr_out, col_valid, col_idx, band_idx, frame_done
  );
endinterface

// File: rtl/median_band_feeder.sv
// Buffers SIZE raster rows, then drains them one column per cycle; consecutive
// bands overlap by two rows so the downstream median outputs tile the frame.
module median_band_feeder #(
  parameter int SIZE   = 10,
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 66
) (
  input  logic                 clk,
  input  logic                 rst,
  median_band_feeder_if.slave  bus
);
  localparam int NBANDS = (HEIGHT - 2) / (SIZE - 2);
  localparam int RW     = $clog2(SIZE);
  localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW     = (NBANDS > 1) ? $clog2(NBANDS) : 1;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CARRY = 2'd2;

  localparam logic [RW-1:0] ROW_LAST  = RW'(SIZE - 1);
  localparam logic [RW-1:0] ROW_CARRY = RW'(2);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [BW-1:0] BAND_LAST = BW'(NBANDS - 1);

  logic [7:0]    mem [SIZE][WIDTH];

  logic [1:0]    state_r, state_n_s;
  logic [RW-1:0] wr_row_r, wr_row_n_s;
  logic [CW-1:0] wr_col_r, wr_col_n_s;
  logic [CW-1:0] rd_col_r, rd_col_n_s;
  logic [BW-1:0] band_r, band_n_s;

  logic          pix_ready_r;
  logic          col_valid_r;
  logic [7:0]    arr_out_r [SIZE-1:0];
  logic [CW-1:0] col_idx_r;
  logic [BW-1:0] band_idx_r;
  logic          frame_done_r;

  logic          accept_s;
  logic          resync_s;
  logic          we_s;
  logic [RW-1:0] wa_row_s;
  logic [CW-1:0] wa_col_s;
  logic          drain_n_s;
  logic [7:0]    arr_n_s [SIZE-1:0];
  logic [CW-1:0] col_idx_n_s;
  logic [BW-1:0] band_idx_n_s;
  logic          frame_done_n_s;

  assign accept_s = bus.pix_valid && pix_ready_r;
  assign resync_s = bus.frame_start &&
                    !((band_r == '0) && (wr_row_r == '0) && (wr_col_r == '0));

  // Next-state logic for the band counters and the write address.
  always_comb begin
    state_n_s  = state_r;
    wr_row_n_s = wr_row_r;
    wr_col_n_s = wr_col_r;
    rd_col_n_s = rd_col_r;
    band_n_s   = band_r;
    we_s       = 1'b0;
    wa_row_s   = wr_row_r;
    wa_col_s   = wr_col_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          we_s = 1'b1;
          // A misplaced frame_start restarts band 0 with this pixel at (0,0).
          if (resync_s) begin
            wa_row_s = '0;
            wa_col_s = '0;
            band_n_s = '0;
          end else begin
            wa_row_s = wr_row_r;
          end
          if (wa_col_s == COL_LAST) begin
            wr_col_n_s = '0;
            if (wa_row_s == ROW_LAST) begin
              state_n_s  = DRAIN;
              rd_col_n_s = '0;
              wr_row_n_s = '0;
            end else begin
              wr_row_n_s = wa_row_s + 1'b1;
            end
          end else begin
            wr_col_n_s = wa_col_s + 1'b1;
            wr_row_n_s = wa_row_s;
          end
        end else begin
          we_s = 1'b0;
        end
      end
      DRAIN: begin
        if (rd_col_r == COL_LAST) begin
          rd_col_n_s = '0;
          if (band_r == BAND_LAST) begin
            state_n_s  = FILL;
            band_n_s   = '0;
            wr_row_n_s = '0;
            wr_col_n_s = '0;
          end else begin
            state_n_s = CARRY;
            band_n_s  = band_r + 1'b1;
          end
        end else begin
          rd_col_n_s = rd_col_r + 1'b1;
        end
      end
      CARRY: begin
        state_n_s  = FILL;
        wr_row_n_s = ROW_CARRY;
        wr_col_n_s = '0;
      end
      default: begin
        state_n_s  = FILL;
        wr_row_n_s = '0;
        wr_col_n_s = '0;
        rd_col_n_s = '0;
        band_n_s   = '0;
      end
    endcase
  end

  // Output values for the coming cycle, so every output leaves a register.
  always_comb begin
    drain_n_s      = (state_n_s == DRAIN);
    col_idx_n_s    = drain_n_s ? rd_col_n_s : '0;
    band_idx_n_s   = drain_n_s ? band_n_s : band_idx_r;
    frame_done_n_s = drain_n_s && (rd_col_n_s == COL_LAST) && (band_n_s == BAND_LAST);
    for (int r = 0; r < SIZE; r++) begin
      arr_n_s[RW'(r)] = 8'd0;
      // Bypass covers the pixel written on the same edge that enters DRAIN.
      if (!drain_n_s) begin
        arr_n_s[RW'(r)] = 8'd0;
      end else if (we_s && (wa_row_s == RW'(r)) && (wa_col_s == rd_col_n_s)) begin
        arr_n_s[RW'(r)] = bus.pix_in;
      end else begin
        arr_n_s[RW'(r)] = mem[RW'(r)][rd_col_n_s];
      end
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FILL;
      wr_row_r     <= '0;
      wr_col_r     <= '0;
      rd_col_r     <= '0;
      band_r       <= '0;
      pix_ready_r  <= 1'b1;
      col_valid_r  <= 1'b0;
      arr_out_r    <= '{default: 8'd0};
      col_idx_r    <= '0;
      band_idx_r   <= '0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      wr_row_r     <= wr_row_n_s;
      wr_col_r     <= wr_col_n_s;
      rd_col_r     <= rd_col_n_s;
      band_r       <= band_n_s;
      pix_ready_r  <= (state_n_s == FILL);
      col_valid_r  <= drain_n_s;
      arr_out_r    <= arr_n_s;
      col_idx_r    <= col_idx_n_s;
      band_idx_r   <= band_idx_n_s;
      frame_done_r <= frame_done_n_s;
    end
  end

  // Band storage: pixel writes during FILL, two-row overlap copy during CARRY.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wa_row_s][wa_col_s] <= bus.pix_in;
    end else if (state_r == CARRY) begin
      for (int c = 0; c < WIDTH; c++) begin
        mem[RW'(0)][CW'(c)] <= mem[RW'(SIZE - 2)][CW'(c)];
        mem[RW'(1)][CW'(c)] <= mem[RW'(SIZE - 1)][CW'(c)];
      end
    end
  end

  assign bus.pix_ready  = pix_ready_r;
  assign bus.col_valid  = col_valid_r;
  assign bus.arr_out    = arr_out_r;
  assign bus.col_idx    = col_idx_r;
  assign bus.band_idx   = band_idx_r;
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_median_band_feeder.sv
// Scoreboard bench: expected columns come from whole-frame arrays sliced into
// overlapping bands; a negedge monitor compares every presented column.
module tb_median_band_feeder;
  localparam int SIZE   = 4;
  localparam int WIDTH  = 4;
  localparam int HEIGHT = 6;
  localparam int NB     = (HEIGHT - 2) / (SIZE - 2);

  typedef struct packed {
    logic [SIZE*8-1:0] pix;
    logic [31:0]       col;
    logic [31:0]       band;
    logic              done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  median_band_feeder_if #(.SIZE(SIZE), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) bus();
  median_band_feeder #(.SIZE(SIZE), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         last_acc_cyc = -100;
  int         frames_exp = 0;
  int         done_seen = 0;
  bit         gaps = 1'b0;
  exp_t       sbq[$];
  logic [7:0] fr [HEIGHT][WIDTH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SIZE*8-1:0] packed_out();
    logic [SIZE*8-1:0] a;
    for (int r = 0; r < SIZE; r++) a[r*8 +: 8] = bus.arr_out[r];
    return a;
  endfunction

  task automatic chk_reset();
    chk("rst_ready", bus.pix_ready, 1);
    chk("rst_col_valid", bus.col_valid, 0);
    chk("rst_arr_out", packed_out(), 0);
    chk("rst_col_idx", bus.col_idx, 0);
    chk("rst_band_idx", bus.band_idx, 0);
    chk("rst_frame_done", bus.frame_done, 0);
  endtask

  task automatic build_frame(input bit pattern);
    for (int r = 0; r < HEIGHT; r++)
      for (int c = 0; c < WIDTH; c++)
        fr[r][c] = pattern ? 8'(r * 16 + c) : 8'($urandom_range(255, 0));
  endtask

  task automatic send_beat(input logic [7:0] v, input bit fs);
    bit rdy;
    bit ok;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.pix_in = v;
    bus.frame_start = fs;
    bus.pix_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      rdy = bus.pix_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    bus.frame_start = 1'b0;
  endtask

  // Bands overlap by two rows: band b holds frame rows b*(SIZE-2) .. +SIZE-1.
  task automatic send_frame(input bit fs_first);
    exp_t e;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < WIDTH; c++) begin
        for (int r = 0; r < SIZE; r++) e.pix[r*8 +: 8] = fr[b*(SIZE-2) + r][c];
        e.col  = c;
        e.band = b;
        e.done = (b == NB - 1) && (c == WIDTH - 1);
        sbq.push_back(e);
      end
    end
    frames_exp++;
    for (int r = 0; r < HEIGHT; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        send_beat(fr[r][c], (r == 0 && c == 0) ? fs_first : 1'b0);
        if (r >= SIZE - 1 && ((r - (SIZE - 1)) % (SIZE - 2)) == 0 && c == WIDTH - 1)
          last_acc_cyc = cyc;
      end
    end
  endtask

  // Monitor: pops one expectation per presented column and checks idle/carry timing.
  initial begin
    exp_t e;
    int   run = 0;
    bit   prev_cv = 1'b0;
    bit   prev_done = 1'b0;
    bit   carry_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0;
        prev_cv = 1'b0;
        prev_done = 1'b0;
        carry_pend = 1'b0;
      end else begin
        if (carry_pend) begin
          chk("ready_after_carry", bus.pix_ready, 1);
          carry_pend = 1'b0;
        end
        if (bus.col_valid) begin
          if (!prev_cv) chk("drain_latency_cycle", cyc, last_acc_cyc);
          chk("ready_low_in_drain", bus.pix_ready, 0);
          if (sbq.size() == 0) begin
            chk("unexpected_column", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("col_data", packed_out(), e.pix);
            chk("col_idx", bus.col_idx, e.col);
            chk("band_idx", bus.band_idx, e.band);
            chk("frame_done", bus.frame_done, e.done);
          end
          if (bus.frame_done) done_seen++;
          run++;
        end else begin
          chk("idle_outputs", {packed_out(), bus.col_idx, bus.frame_done}, 0);
          if (prev_cv) begin
            chk("col_valid_run_len", run, WIDTH);
            run = 0;
            if (prev_done) begin
              chk("ready_after_frame", bus.pix_ready, 1);
            end else begin
              chk("carry_idle_ready", bus.pix_ready, 0);
              carry_pend = 1'b1;
            end
          end
        end
        prev_cv = bus.col_valid;
        prev_done = bus.frame_done;
      end
    end
  end

  initial begin
    int wait_cnt;
    bus.pix_in = 8'd0;
    bus.pix_valid = 1'b0;
    bus.frame_start = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    @(posedge clk); #1;

    // Partial band, then reset: that data must never show up.
    build_frame(1'b0);
    for (int i = 0; i < 5; i++) send_beat(fr[i / WIDTH][i % WIDTH], i == 0);
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    gaps = 1'b0;
    build_frame(1'b1);
    send_frame(1'b1);
    bus.pix_valid = 1'b0;

    gaps = 1'b1;
    build_frame(1'b0);
    send_frame(1'b1);

    // Nine beats of an abandoned frame; the next frame_start lands at row 2, col 1.
    build_frame(1'b0);
    for (int i = 0; i < 2 * WIDTH + 1; i++) send_beat(fr[i / WIDTH][i % WIDTH], i == 0);
    build_frame(1'b0);
    send_frame(1'b1);

    gaps = 1'b0;
    build_frame(1'b1);
    send_frame(1'b0);
    build_frame(1'b0);
    send_frame(1'b1);
    bus.pix_valid = 1'b0;

    wait_cnt = 0;
    while (sbq.size() != 0 && wait_cnt < 500) begin
      @(posedge clk);
      wait_cnt++;
    end
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("frame_done_count", done_seen, frames_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/median_band_feeder.md
Name:
median_band_feeder

Overview:
- Source side of the scalable median array: converts a raster pixel stream (one 8-bit pixel per accepted beat, row-major) into row-parallel columns for the median filter.
- Buffers a band of SIZE rows, then drains it one column per cycle as SIZE parallel pixels.
- Consecutive bands overlap by 2 rows, so the downstream filter's SIZE-2 outputs per band tile the frame without gaps.

Parameters:
SIZE, 10, rows per band; must match the median array's SIZE, >=3
WIDTH, 64, pixels per row (columns per band)
HEIGHT, 66, rows per frame; (HEIGHT-2) must be a multiple of (SIZE-2)
NBANDS (localparam), (HEIGHT-2)/(SIZE-2), bands per frame (8 at defaults)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
pix_in  in  8  raster pixel
pix_valid  in  1  pix_in valid
frame_start  in  1  qualifies the pixel as row 0, col 0 of a frame
pix_ready  out  1  feeder can accept; beat accepted when pix_valid && pix_ready
arr_out  out  8 x SIZE (unpacked [SIZE-1:0])  column pixels; arr_out[r] = band row r
col_valid  out  1  arr_out holds a valid column
col_idx  out  $clog2(WIDTH)  column index of arr_out
band_idx  out  $clog2(NBANDS)  band index of arr_out
frame_done  out  1  one-cycle pulse with last column of last band

Behaviour:
- Storage: mem[SIZE][WIDTH] x 8 bits.
- Counters: wr_row, wr_col, rd_col, band.
- States: FILL, DRAIN, CARRY.
- Reset (async, any state): state=FILL, wr_row=0, wr_col=0, rd_col=0, band=0.
  - Outputs on reset: pix_ready=1, col_valid=0, arr_out=0, col_idx=0, band_idx=0, frame_done=0.
  - mem contents are not cleared; any partial band is discarded.
- FILL:
  - pix_ready=1.
  - On each accept: mem[wr_row][wr_col] <= pix_in, then wr_col increments.
  - At wr_col=WIDTH-1: wr_col wraps to 0 and wr_row increments.
  - On accept of (SIZE-1, WIDTH-1): go to DRAIN, rd_col=0.
- Band start rows:
  - Band 0 fills from wr_row=0 (SIZE*WIDTH beats).
  - Bands 1..NBANDS-1 fill from wr_row=2 ((SIZE-2)*WIDTH beats).
- frame_start:
  - Sampled only on accepted beats.
  - If asserted on a beat that is not band 0, row 0, col 0: resynchronise. Band 0 is restarted with this pixel written at (0,0), wr_col=1, and the partial band is dropped.
  - frame_start deasserted at band 0 (0,0) is legal; the pixel is accepted as frame start.
- DRAIN:
  - pix_ready=0, col_valid=1.
  - arr_out[r] = mem[r][rd_col] for all r; col_idx=rd_col; band_idx=band.
  - rd_col increments each cycle with no backpressure, because the median array is free-running.
  - Column 0 is visible in the first cycle after the edge that accepted the last fill pixel (1-cycle latency).
  - Exactly WIDTH consecutive col_valid cycles per band.
- End of DRAIN (rd_col=WIDTH-1):
  - If band=NBANDS-1: frame_done=1 in that same cycle; next state FILL, band=0, wr_row=0.
  - Otherwise: next state CARRY, band+1.
- CARRY (1 cycle):
  - pix_ready=0, col_valid=0.
  - mem[0][*] <= mem[SIZE-2][*] and mem[1][*] <= mem[SIZE-1][*].
  - Then FILL with wr_row=2, wr_col=0.
- Outside DRAIN: arr_out=0, col_idx=0, band_idx holds its last value, frame_done=0.
- pix_valid while pix_ready=0 is legal; the upstream holds the pixel, and no beat is lost or duplicated.

Test Plan:
- Bench params SIZE=4, WIDTH=4, HEIGHT=6 (NBANDS=2); pixel value = row*16+col.
- Reset mid-FILL after 5 beats, then restream from frame_start -> pix_ready=1 and outputs 0 during reset; the first band drains columns from the new data only.
- Band 0: 16 beats with pix_valid held high -> pix_ready drops the cycle after beat 16; col_valid for 4 cycles.
  - Column 0: arr_out = {0x00,0x10,0x20,0x30} (index 0..3), band_idx=0.
  - Column 3: {0x03,0x13,0x23,0x33}.
- CARRY and band 1 -> exactly one idle cycle, then 8 beats (rows 4,5).
  - Column 1: {0x21,0x31,0x41,0x51}, band_idx=1.
  - frame_done=1 only with col_idx=3 of band 1; pix_ready=1 the next cycle.
- Random pix_valid gaps (~50%) -> identical column contents; col_valid cycles remain contiguous (4 per band).
- frame_start asserted at band 0 row 2, col 1 -> resync: that pixel lands at (0,0); band 0 drains after 15 further beats.
- Two back-to-back frames -> band_idx sequence 0,1,0,1; frame_done exactly twice.
